frame_deser: RTL and testbench
==============================

FRAME_DESER -- requirements
Module: frame_deser

Interface
REQ-001 The block SHALL have parameter SYNC_WORD, default 8'hA5: the frame sync pattern, MSB first.
REQ-002 The block SHALL have parameter FRAME_BYTES, default 4: payload bytes per frame, legal range 1..255.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_bit  input  1  serial data from the upstream shift register output, MSB first.
REQ-006 The block SHALL have port i_bit_en  input  1  qualifies i_bit; bits are ignored when low.
REQ-007 The block SHALL have port o_data  output  8  head-of-buffer payload byte.
REQ-008 The block SHALL have port o_last  output  1  o_data is the final byte of its frame.
REQ-009 The block SHALL have port o_valid  output  1  o_data/o_last are valid.
REQ-010 The block SHALL have port i_ready  input  1  consumer accepts the byte; a transfer occurs when o_valid and i_ready are both high.
REQ-011 The block SHALL have port o_in_frame  output  1  high while in DATA state.
REQ-012 The block SHALL have port o_overflow  output  1  sticky flag: a byte was dropped.
REQ-013 The block SHALL have port i_clr_ovf  input  1  clears o_overflow.

Function
REQ-014 The FSM SHALL have two states, HUNT and DATA; the reset state is HUNT.
- HUNT behaviour: on each i_bit_en, an 8-bit window SHALL shift {window[6:0], i_bit}.
- HUNT exit: when the shifted value equals SYNC_WORD, the next state SHALL be DATA, with bit_cnt=0 and byte_cnt=0.
REQ-015 In DATA, each i_bit_en SHALL shift i_bit into the assembly register; bit_cnt SHALL count 0..7.
REQ-016 On the 8th bit the byte {asm[6:0], i_bit} SHALL be pushed with last=(byte_cnt==FRAME_BYTES-1); byte_cnt SHALL increment and bit_cnt SHALL wrap to 0.
REQ-017 After the push of the last byte, the state SHALL return to HUNT with the window cleared to 8'h00, so a new sync requires a fresh pattern.
- Consequence: sync detection never overlaps payload bits.
REQ-018 Latency: o_valid SHALL rise the cycle after the clock edge that samples the 8th bit, provided the buffer was empty.
REQ-019 The output buffer SHALL be a 2-entry FIFO holding {data, last}; o_valid = not empty; output order is FIFO.
REQ-020 Push and pop in the same cycle SHALL both be honoured, including when the buffer is full.
REQ-021 Overflow: a push while full and not popping SHALL drop the new byte and set o_overflow.
- The frame byte count still advances, so frame alignment is preserved.
REQ-022 o_overflow SHALL remain set until i_clr_ovf is high at a clock edge.
- If i_clr_ovf and a new drop coincide, set SHALL win.
REQ-023 o_data/o_last SHALL hold stable while o_valid is high and i_ready is low.
REQ-024 With i_bit_en low, no window, assembly or counter state SHALL change; pops SHALL still proceed.

Reset
REQ-025 On rst high, the block SHALL asynchronously force: state=HUNT, window=0, asm=0, bit_cnt=0, byte_cnt=0, FIFO empty.
- Output values during reset: o_valid=0, o_data=0, o_last=0, o_in_frame=0, o_overflow=0.
REQ-026 Reset mid-frame SHALL discard the partial byte and all buffered bytes; no o_last is emitted for the aborted frame.
REQ-027 Reset release SHALL be synchronous to clk; the first bit sampled is on the first edge after rst falls.

Structure
REQ-028 A shared package frame_deser_pkg SHALL hold the state typedef (HUNT, DATA), the default SYNC_WORD and FRAME_BYTES, and the FIFO depth constant 2.
REQ-029 The output buffer SHALL be a separate sub-module fifo2 (width 9, depth 2, push/pop/full/empty); the FSM and datapath SHALL reside in frame_deser.

Verification
REQ-030 Bit stream A5 11 22 33 44 with i_bit_en=1 and i_ready=1 -> out 11,22,33,44; o_last only on 44; o_in_frame high from the cycle after the sync's last bit until the cycle after 44's last bit.
REQ-031 Noise 5A then A5 then 4 bytes DE AD BE EF -> exactly one frame, DE AD BE EF, out; no false sync on 5A.
REQ-032 i_ready=0 for whole frame 01 02 03 04 -> 01, 02 retained; 03, 04 dropped; o_overflow=1; then i_ready=1 -> 01, 02 out, o_last=0 on both.
REQ-033 i_bit_en toggling every other cycle with frame A5 10 20 30 40 -> same bytes out, latency measured in enabled bits only.
REQ-034 rst pulse after 12 payload bits of a frame -> o_valid=0 immediately; a following A5 + 4 bytes frame is received intact.
REQ-035 Full buffer with pop and 8th bit in the same cycle -> no drop; o_overflow stays 0; i_clr_ovf coinciding with a new drop -> o_overflow stays 1.

Source files
------------

// File: rtl/frame_deser_pkg.sv
// -----------------------------------------------------------------------------
// frame_deser_pkg
// Shared definitions for the serial frame deserializer: FSM state type,
// default sync pattern / payload length, and output buffer geometry.
// -----------------------------------------------------------------------------
package frame_deser_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_t;

    localparam logic [7:0]  DEF_SYNC_WORD   = 8'hA5;
    localparam int unsigned DEF_FRAME_BYTES = 4;

    // Output buffer: 2 entries of {last, data[7:0]}
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_WIDTH = 9;

endpackage

// File: rtl/frame_deser_fifo2.sv
// -----------------------------------------------------------------------------
// fifo2
// Two-entry FIFO used as the deserializer output buffer.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : write i_data (ignored when full unless popping in same cycle)
//   i_data    : word to write
//   i_pop     : remove head entry (ignored when empty)
//   o_data    : head entry, held stable until popped
//   o_full    : both entries occupied
//   o_empty   : no entries occupied
// -----------------------------------------------------------------------------
module fifo2
    import frame_deser_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full  = (r_count == 2'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    // When full, a simultaneous pop frees the slot the write pointer targets.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/frame_deser.sv
// -----------------------------------------------------------------------------
// frame_deser
// Serial frame deserializer: hunts for SYNC_WORD in an MSB-first bit stream,
// then assembles FRAME_BYTES payload bytes and queues them in a 2-entry
// output buffer with a last-byte marker.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_bit       : serial data, MSB first
//   i_bit_en    : qualifies i_bit
//   o_data      : head-of-buffer payload byte
//   o_last      : o_data is the final byte of its frame
//   o_valid     : o_data/o_last valid
//   i_ready     : consumer accepts the head byte
//   o_in_frame  : FSM is in DATA state
//   o_overflow  : sticky, a byte was dropped because the buffer was full
//   i_clr_ovf   : clears o_overflow (a coincident drop wins)
// -----------------------------------------------------------------------------
module frame_deser
    import frame_deser_pkg::*;
#(
    parameter logic [7:0]  SYNC_WORD   = DEF_SYNC_WORD,
    parameter int unsigned FRAME_BYTES = DEF_FRAME_BYTES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_bit,
    input  logic       i_bit_en,
    output logic [7:0] o_data,
    output logic       o_last,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_in_frame,
    output logic       o_overflow,
    input  logic       i_clr_ovf
);

    state_t     r_state;
    logic [7:0] r_window;
    logic [6:0] r_asm;       // only the 7 most recent bits are needed to form a byte
    logic [2:0] r_bit_cnt;
    logic [7:0] r_byte_cnt;
    logic       r_overflow;

    logic [7:0] w_window_next;
    logic       w_byte_done;
    logic       w_last;
    logic [8:0] w_push_word;
    logic [8:0] w_fifo_q;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_drop;

    assign w_window_next = {r_window[6:0], i_bit};
    assign w_byte_done   = (r_state == DATA) && i_bit_en && (r_bit_cnt == 3'd7);
    assign w_last        = (r_byte_cnt == 8'(FRAME_BYTES - 1));
    assign w_push_word   = {w_last, r_asm, i_bit};
    assign w_pop         = !w_empty && i_ready;
    assign w_drop        = w_byte_done && w_full && !w_pop;

    fifo2 #(
        .WIDTH (FIFO_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_byte_done),
        .i_data  (w_push_word),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= HUNT;
            r_window   <= '0;
            r_asm      <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Set has priority over clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end

            if (i_bit_en) begin
                case (r_state)
                    HUNT: begin
                        r_window <= w_window_next;
                        if (w_window_next == SYNC_WORD) begin
                            r_state    <= DATA;
                            r_bit_cnt  <= '0;
                            r_byte_cnt <= '0;
                        end
                    end
                    DATA: begin
                        r_asm <= {r_asm[5:0], i_bit};
                        if (r_bit_cnt == 3'd7) begin
                            // Byte count advances even if the byte was dropped.
                            r_bit_cnt  <= '0;
                            r_byte_cnt <= r_byte_cnt + 8'd1;
                            if (w_last) begin
                                r_state    <= HUNT;
                                r_window   <= '0;
                                r_byte_cnt <= '0;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign o_valid    = !w_empty;
    assign o_data     = w_fifo_q[7:0];
    assign o_last     = w_fifo_q[8];
    assign o_in_frame = (r_state == DATA);
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_frame_deser.sv
// -----------------------------------------------------------------------------
// tb_frame_deser
// Self-checking bench for frame_deser. Expected {last, data} words are queued
// when payload stimulus is driven; a negedge monitor pops and compares them on
// every transfer and checks head stability while stalled.
// -----------------------------------------------------------------------------
module tb_frame_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_bit;
    logic       i_bit_en;
    logic       i_ready;
    logic       i_clr_ovf;
    logic [7:0] o_data;
    logic       o_last;
    logic       o_valid;
    logic       o_in_frame;
    logic       o_overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] exp_q [$];
    logic [8:0] mon_exp;
    logic       mon_hold;
    logic [8:0] mon_word;

    always #5 clk = ~clk;

    frame_deser #(
        .SYNC_WORD   (8'hA5),
        .FRAME_BYTES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_bit      (i_bit),
        .i_bit_en   (i_bit_en),
        .o_data     (o_data),
        .o_last     (o_last),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_in_frame (o_in_frame),
        .o_overflow (o_overflow),
        .i_clr_ovf  (i_clr_ovf)
    );

    // Transfer monitor: a transfer happens at the next posedge when
    // o_valid && i_ready is seen here.
    always @(negedge clk) begin
        if (rst) begin
            mon_hold = 1'b0;
        end else begin
            if (mon_hold && o_valid) begin
                n_vec++;
                if ({o_last, o_data} !== mon_word) begin
                    n_err++;
                    $display("FAIL hold_stable: got last=%b data=%h, required last=%b data=%h",
                             o_last, o_data, mon_word[8], mon_word[7:0]);
                end
            end
            if (o_valid && i_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_byte: got last=%b data=%h, required no output",
                             o_last, o_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({o_last, o_data} !== mon_exp) begin
                        n_err++;
                        $display("FAIL byte_out: got last=%b data=%h, required last=%b data=%h",
                                 o_last, o_data, mon_exp[8], mon_exp[7:0]);
                    end
                end
            end
            mon_hold = o_valid && !i_ready;
            mon_word = {o_last, o_data};
        end
    end

    // All driver tasks start and end at posedge + #1.
    task automatic send_bit(input logic b);
        i_bit    = b;
        i_bit_en = 1'b1;
        @(posedge clk);
        #1;
        i_bit_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
            if (gap) idle(1);
        end
    endtask

    task automatic send_7bits(input logic [7:0] v, input bit gap);
        for (int i = 7; i >= 1; i--) begin
            send_bit(v[i]);
            if (gap) idle(1);
        end
    endtask

    task automatic expect_byte(input logic [7:0] v, input logic last);
        exp_q.push_back({last, v});
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || o_valid) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_vec++;
        if (exp_q.size() != 0 || o_valid) begin
            n_err++;
            $display("FAIL %s_drain: got %0d bytes pending, o_valid=%b, required 0 pending, o_valid=0",
                     name, exp_q.size(), o_valid);
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        i_bit     = 1'b0;
        i_bit_en  = 1'b0;
        i_ready   = 1'b0;
        i_clr_ovf = 1'b0;
        #2;
        n_vec++;
        if ({o_valid, o_data, o_last, o_in_frame, o_overflow} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b data=%h last=%b in_frame=%b ovf=%b, required all 0",
                     o_valid, o_data, o_last, o_in_frame, o_overflow);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic;
        logic [7:0] v;
        i_ready = 1'b1;
        n_vec++;
        if (o_in_frame !== 1'b0) begin
            n_err++;
            $display("FAIL basic_hunt: got in_frame=%b, required 0", o_in_frame);
        end
        send_byte(8'hA5, 1'b0);
        n_vec++;
        if (o_in_frame !== 1'b1) begin
            n_err++;
            $display("FAIL basic_in_frame: got %b, required 1", o_in_frame);
        end
        v = 8'h11;
        expect_byte(v, 1'b0);
        send_7bits(v, 1'b0);
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_early_valid: got o_valid=%b, required 0", o_valid);
        end
        send_bit(v[0]);
        n_vec++;
        if (o_valid !== 1'b1 || o_data !== 8'h11) begin
            n_err++;
            $display("FAIL basic_latency: got valid=%b data=%h, required valid=1 data=11",
                     o_valid, o_data);
        end
        expect_byte(8'h22, 1'b0);
        send_byte(8'h22, 1'b0);
        expect_byte(8'h33, 1'b0);
        send_byte(8'h33, 1'b0);
        n_vec++;
        if (o_in_frame !== 1'b1) begin
            n_err++;
            $display("FAIL basic_in_frame_mid: got %b, required 1", o_in_frame);
        end
        expect_byte(8'h44, 1'b1);
        send_byte(8'h44, 1'b0);
        n_vec++;
        if (o_in_frame !== 1'b0) begin
            n_err++;
            $display("FAIL basic_frame_end: got in_frame=%b, required 0", o_in_frame);
        end
        wait_drain("basic");
    endtask

    task automatic test_noise;
        i_ready = 1'b1;
        send_byte(8'h5A, 1'b0);
        n_vec++;
        if (o_in_frame !== 1'b0) begin
            n_err++;
            $display("FAIL noise_false_sync: got in_frame=%b, required 0", o_in_frame);
        end
        send_byte(8'hA5, 1'b0);
        n_vec++;
        if (o_in_frame !== 1'b1) begin
            n_err++;
            $display("FAIL noise_sync: got in_frame=%b, required 1", o_in_frame);
        end
        expect_byte(8'hDE, 1'b0);
        send_byte(8'hDE, 1'b0);
        expect_byte(8'hAD, 1'b0);
        send_byte(8'hAD, 1'b0);
        expect_byte(8'hBE, 1'b0);
        send_byte(8'hBE, 1'b0);
        expect_byte(8'hEF, 1'b1);
        send_byte(8'hEF, 1'b0);
        wait_drain("noise");
        idle(10);
    endtask

    task automatic test_overflow;
        i_ready = 1'b0;
        n_vec++;
        if (o_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_initial: got %b, required 0", o_overflow);
        end
        send_byte(8'hA5, 1'b0);
        expect_byte(8'h01, 1'b0);
        expect_byte(8'h02, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        n_vec++;
        if (o_overflow !== 1'b1 || o_in_frame !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_set: got ovf=%b in_frame=%b, required ovf=1 in_frame=0",
                     o_overflow, o_in_frame);
        end
        n_vec++;
        if (o_valid !== 1'b1 || o_data !== 8'h01) begin
            n_err++;
            $display("FAIL ovf_head: got valid=%b data=%h, required valid=1 data=01",
                     o_valid, o_data);
        end
        i_ready = 1'b1;
        wait_drain("ovf");
        n_vec++;
        if (o_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: got %b, required 1", o_overflow);
        end
        i_clr_ovf = 1'b1;
        idle(1);
        i_clr_ovf = 1'b0;
        n_vec++;
        if (o_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got %b, required 0", o_overflow);
        end
    endtask

    task automatic test_en_toggle;
        logic [7:0] v;
        i_ready = 1'b1;
        send_byte(8'hA5, 1'b1);
        v = 8'h10;
        expect_byte(v, 1'b0);
        send_7bits(v, 1'b1);
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL en_early_valid: got o_valid=%b, required 0", o_valid);
        end
        send_bit(v[0]);
        n_vec++;
        if (o_valid !== 1'b1 || o_data !== 8'h10) begin
            n_err++;
            $display("FAIL en_latency: got valid=%b data=%h, required valid=1 data=10",
                     o_valid, o_data);
        end
        idle(1);
        expect_byte(8'h20, 1'b0);
        send_byte(8'h20, 1'b1);
        expect_byte(8'h30, 1'b0);
        send_byte(8'h30, 1'b1);
        expect_byte(8'h40, 1'b1);
        send_byte(8'h40, 1'b1);
        wait_drain("en_toggle");
    endtask

    task automatic test_reset_mid;
        logic [7:0] v;
        i_ready = 1'b0;
        send_byte(8'hA5, 1'b0);
        expect_byte(8'h55, 1'b0);
        send_byte(8'h55, 1'b0);
        v = 8'h66;
        for (int i = 7; i >= 4; i--) begin
            send_bit(v[i]);
        end
        n_vec++;
        if (o_valid !== 1'b1 || o_in_frame !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre: got valid=%b in_frame=%b, required 1 1", o_valid, o_in_frame);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({o_valid, o_data, o_last, o_in_frame, o_overflow} !== 12'h000) begin
            n_err++;
            $display("FAIL rstmid_async: got valid=%b data=%h last=%b in_frame=%b ovf=%b, required all 0",
                     o_valid, o_data, o_last, o_in_frame, o_overflow);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        i_ready = 1'b1;
        send_byte(8'hA5, 1'b0);
        expect_byte(8'hC1, 1'b0);
        send_byte(8'hC1, 1'b0);
        expect_byte(8'hC2, 1'b0);
        send_byte(8'hC2, 1'b0);
        expect_byte(8'hC3, 1'b0);
        send_byte(8'hC3, 1'b0);
        expect_byte(8'hC4, 1'b1);
        send_byte(8'hC4, 1'b0);
        wait_drain("rstmid");
    endtask

    task automatic test_full_pop;
        logic [7:0] v;
        i_ready = 1'b0;
        send_byte(8'hA5, 1'b0);
        expect_byte(8'h01, 1'b0);
        expect_byte(8'h02, 1'b0);
        expect_byte(8'h03, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        // Pop of 01 coincides with the 8th bit of 03.
        v = 8'h03;
        send_7bits(v, 1'b0);
        i_ready = 1'b1;
        send_bit(v[0]);
        i_ready = 1'b0;
        n_vec++;
        if (o_overflow !== 1'b0 || o_data !== 8'h02) begin
            n_err++;
            $display("FAIL fullpop_nodrop: got ovf=%b head=%h, required ovf=0 head=02",
                     o_overflow, o_data);
        end
        send_byte(8'h04, 1'b0);
        n_vec++;
        if (o_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL fullpop_drop: got ovf=%b, required 1", o_overflow);
        end
        // Clear request on the same edge as another drop.
        send_byte(8'hA5, 1'b0);
        v = 8'h05;
        send_7bits(v, 1'b0);
        i_clr_ovf = 1'b1;
        send_bit(v[0]);
        i_clr_ovf = 1'b0;
        n_vec++;
        if (o_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL fullpop_set_wins: got ovf=%b, required 1", o_overflow);
        end
        send_byte(8'h06, 1'b0);
        send_byte(8'h07, 1'b0);
        send_byte(8'h08, 1'b0);
        i_clr_ovf = 1'b1;
        idle(1);
        i_clr_ovf = 1'b0;
        n_vec++;
        if (o_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL fullpop_clear: got ovf=%b, required 0", o_overflow);
        end
        i_ready = 1'b1;
        wait_drain("fullpop");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_noise();
        test_overflow();
        test_en_toggle();
        test_reset_mid();
        test_full_pop();
        idle(5);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL final_queue: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000, required finish");
        $fatal(1);
    end

endmodule
